// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int DEPTH   = 256;
  localparam int MAX_LEN = DEPTH - 1;
  localparam int WORD_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DATA  = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } loader_state_t;

  // A frame length is usable only if it is non-zero and fits the memory.
  function automatic logic len_ok(input logic [WORD_W-1:0] len);
    return (len != '0) && (int'(len) <= MAX_LEN);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot loader: receives LEN / bytes / CSUM, writes instruction memory from
// address 0 and releases the core from reset once the checksum verifies.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output loader_state_t     dbg_state
);

  // Handshake: a byte transfers on any cycle where in_valid && in_ready.
  // in_ready drops while reload is high, so reload never consumes a byte.

  loader_state_t     state, state_nx;
  logic [WORD_W-1:0] idx, acc, rem;
  logic [WORD_W-1:0] csum_total;
  logic              xfer, data_xfer;

  assign xfer       = in_valid && in_ready;
  assign data_xfer  = xfer && (state == S_DATA);
  assign csum_total = acc + in_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (reload) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (xfer) state_nx = len_ok(in_data) ? S_DATA : S_ERR;
        S_DATA:  if (xfer && rem == WORD_W'(1)) state_nx = S_CHECK;
        S_CHECK: if (xfer) state_nx = (csum_total == '0) ? S_RUN : S_ERR;
        S_RUN:   state_nx = S_RUN;
        S_ERR:   state_nx = S_ERR;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (state inside {S_IDLE, S_DATA, S_CHECK}) && !reload;
    cpu_rst   = (state != S_RUN);
    load_done = (state == S_RUN);
    load_err  = (state == S_ERR);
    dbg_state = state;
  end

  // Byte counter, checksum accumulator and registered write port.
  // A write captured the cycle before reload still issues, since reload
  // only blocks new transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      acc       <= '0;
      rem       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= data_xfer;
      if (data_xfer) begin
        mem_addr  <= idx;
        mem_wdata <= in_data;
      end
      if (reload) begin
        idx <= '0;
        acc <= '0;
        rem <= '0;
      end else if (xfer && state == S_IDLE) begin
        idx <= '0;
        acc <= in_data;
        rem <= in_data;
      end else if (data_xfer) begin
        idx <= idx + WORD_W'(1);
        acc <= acc + in_data;
        rem <= rem - WORD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level reference model feeding an
// expected-write queue, with a separate monitor comparing every mem_we pulse.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic          reload = 1'b0;
  logic          mem_we;
  logic [7:0]    mem_addr, mem_wdata;
  logic          cpu_rst, load_done, load_err;
  loader_state_t dbg_state;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  frm[$];

  imem_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
    .load_done(load_done), .load_err(load_err), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {16'h0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("write", {16'h0, mem_addr, mem_wdata}, {16'h0, e});
        end
      end
    end
  endtask

  // Driver: present one byte, wait (bounded) for it to be accepted.
  task automatic send_byte(input logic [7:0] b, input int gap_mode, output bit ok);
    int gaps;
    bit rdy;
    gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (gaps) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  // Sends frm; expected writes follow directly from the frame contents.
  task automatic send_frame(input int gap_mode, output bit good);
    logic [7:0] len, sum;
    bit ok, ok_len;
    len    = frm[0];
    ok_len = (len != 0) && (int'(len) <= MAX_LEN);
    sum    = 8'h00;
    good   = 1'b0;
    for (int i = 0; i < frm.size(); i++) begin
      send_byte(frm[i], gap_mode, ok);
      if (!ok) return;
      sum = sum + frm[i];
      if (ok_len && i >= 1 && i <= int'(len)) exp_q.push_back({8'(i - 1), frm[i]});
      if (!ok_len) break;
    end
    good = ok_len && (sum == 8'h00) && (frm.size() == int'(len) + 2);
  endtask

  task automatic check_outcome(input string tag, input bit good);
    @(negedge clk);
    check({tag, "_cpu_rst"},   cpu_rst,   !good);
    check({tag, "_load_done"}, load_done, good);
    check({tag, "_load_err"},  load_err,  !good);
    check({tag, "_in_ready"},  in_ready,  1'b0);
    check({tag, "_state"},     dbg_state, good ? S_RUN : S_ERR);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},     dbg_state, S_IDLE);
    check({tag, "_in_ready"},  in_ready,  1'b1);
    check({tag, "_mem_we"},    mem_we,    1'b0);
    check({tag, "_mem_addr"},  mem_addr,  8'h00);
    check({tag, "_mem_wdata"}, mem_wdata, 8'h00);
    check({tag, "_cpu_rst"},   cpu_rst,   1'b1);
    check({tag, "_load_done"}, load_done, 1'b0);
    check({tag, "_load_err"},  load_err,  1'b0);
  endtask

  task automatic do_reload();
    reload   = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("reload_blocks_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    reload = 1'b0;
    @(negedge clk);
    check("reload_state",   dbg_state, S_IDLE);
    check("reload_cpu_rst", cpu_rst,   1'b1);
    check("reload_ready",   in_ready,  1'b1);
    check("reload_flags",   {load_done, load_err}, 2'b00);
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic make_frame(input int len, input bit bad);
    logic [7:0] b, sum, csum;
    frm.delete();
    frm.push_back(8'(len));
    sum = 8'(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      frm.push_back(b);
      sum = sum + b;
    end
    csum = 8'h00 - sum;
    if (bad) csum = csum + 8'($urandom_range(1, 255));
    frm.push_back(csum);
  endtask

  initial begin
    bit good, ok;
    fork monitor(); join_none

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Known-good frame, back-to-back
    frm = '{8'h03, 8'h48, 8'h09, 8'hC5, 8'hE7};
    send_frame(0, good);
    check("good_frame_model", good, 1'b1);
    check_outcome("good_b2b", 1'b1);

    // Same frame, bad checksum
    do_reload();
    frm = '{8'h03, 8'h48, 8'h09, 8'hC5, 8'h00};
    send_frame(0, good);
    check_outcome("bad_csum", good);

    // LEN = 0: error, no writes, then recover
    do_reload();
    frm = '{8'h00};
    send_frame(0, good);
    check_outcome("len_zero", 1'b0);
    repeat (3) @(posedge clk); #1;
    do_reload();
    frm = '{8'h03, 8'h48, 8'h09, 8'hC5, 8'hE7};
    send_frame(0, good);
    check_outcome("after_len_zero", 1'b1);

    // in_valid toggling every cycle
    do_reload();
    send_frame(1, good);
    check_outcome("toggle_valid", 1'b1);

    // reload on the second data byte
    do_reload();
    send_byte(8'h03, 0, ok);
    send_byte(8'h11, 0, ok);
    exp_q.push_back({8'h00, 8'h11});
    in_valid = 1'b1;
    in_data  = 8'h22;
    reload   = 1'b1;
    @(negedge clk);
    check("reload_mid_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    reload   = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("reload_mid_state",   dbg_state, S_IDLE);
    check("reload_mid_cpu_rst", cpu_rst,   1'b1);
    @(posedge clk); #1;
    make_frame(5, 1'b0);
    send_frame(0, good);
    check_outcome("after_reload_mid", 1'b1);

    // rst mid-DATA
    do_reload();
    send_byte(8'h04, 0, ok);
    send_byte(8'hAA, 0, ok);
    exp_q.push_back({8'h00, 8'hAA});
    send_byte(8'hBB, 0, ok);
    exp_q.push_back({8'h01, 8'hBB});
    pulse_rst();
    @(negedge clk);
    check_reset_vals("rst_mid_data");
    @(posedge clk); #1;

    // rst from RUN
    frm = '{8'h03, 8'h48, 8'h09, 8'hC5, 8'hE7};
    send_frame(0, good);
    check_outcome("pre_rst_run", 1'b1);
    pulse_rst();
    @(negedge clk);
    check_reset_vals("rst_from_run");
    @(posedge clk); #1;

    // Randomized frames with random valid gaps
    for (int n = 0; n < 30; n++) begin
      do_reload();
      if ($urandom_range(0, 9) == 0) make_frame(0, 1'b0);
      else make_frame(int'($urandom_range(1, 16)), $urandom_range(0, 3) == 0);
      send_frame(2, good);
      check_outcome("random", good);
    end

    // Long frame reaching the top of memory
    do_reload();
    make_frame(MAX_LEN, 1'b0);
    send_frame(0, good);
    check_outcome("max_len", 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pending_writes", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
